// File: rtl/sccb_master_if.sv
// Request/status bundle between the camera init sequencer and the SCCB master.
interface sccb_master_if;
  logic       ena;
  logic [7:0] addr;
  logic [7:0] sub_addr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       busy;
  logic       ack_err;

  modport master (input ena, addr, sub_addr, data_wr, output data_rd, busy, ack_err);
  modport slave  (output ena, addr, sub_addr, data_wr, input data_rd, busy, ack_err);
endinterface

// File: rtl/sccb_master.sv
// Byte-level SCCB master: single-register write, or two-phase register read,
// on an open-drain SCL/SDA pair. Each bit slot is four quarter-phase ticks.
module sccb_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic          clk,
  input  logic          rst,
  sccb_master_if.master req,
  output wire           scl,
  inout  wire           sda
);
  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, RX_ACK, RX_BYTE, TX_NACK, STOP, BUS_FREE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          phase2_q, phase2_d;
  logic [7:0]    addr_q, addr_d, sub_q, sub_d, wdat_q, wdat_d;
  logic [7:0]    rx_q, rx_d, data_rd_q, data_rd_d;
  logic          ack_err_q, ack_err_d, busy_q, busy_d;
  logic          scl_low_q, scl_low_d, sda_low_q, sda_low_d;
  logic [1:0]    sda_sync_q, sda_sync_d;

  logic       tick, slot_end, sda_in, tx_bit;
  logic [1:0] last_byte;
  logic [7:0] tx_byte;

  assign tick      = (state_q != IDLE) && (cnt_q == CW'(CLK_DIV - 1));
  assign slot_end  = tick && (qtr_q == 2'd3);
  assign sda_in    = sda_sync_q[1];
  assign last_byte = addr_q[0] ? 2'd1 : 2'd2;
  assign tx_bit    = tx_byte[bit_q];

  // First byte carries W during the read's address/sub-address phase.
  always_comb begin
    unique case (byte_q)
      2'd0:    tx_byte = phase2_q ? addr_q : {addr_q[7:1], 1'b0};
      2'd1:    tx_byte = sub_q;
      default: tx_byte = wdat_q;
    endcase
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= 3'd7;
      byte_q     <= '0;
      phase2_q   <= 1'b0;
      addr_q     <= '0;
      sub_q      <= '0;
      wdat_q     <= '0;
      rx_q       <= '0;
      data_rd_q  <= '0;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      phase2_q   <= phase2_d;
      addr_q     <= addr_d;
      sub_q      <= sub_d;
      wdat_q     <= wdat_d;
      rx_q       <= rx_d;
      data_rd_q  <= data_rd_d;
      ack_err_q  <= ack_err_d;
      busy_q     <= busy_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  // Next-state logic; every non-idle state ends on the last quarter of its slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req.ena) state_d = START;
      START:    if (slot_end) state_d = TX_BYTE;
      TX_BYTE:  if (slot_end && bit_q == 3'd0) state_d = RX_ACK;
      RX_ACK: begin
        if (slot_end) begin
          if (ack_err_q)               state_d = STOP;
          else if (phase2_q)           state_d = RX_BYTE;
          else if (byte_q == last_byte) state_d = STOP;
          else                         state_d = TX_BYTE;
        end
      end
      RX_BYTE:  if (slot_end && bit_q == 3'd0) state_d = TX_NACK;
      TX_NACK:  if (slot_end) state_d = STOP;
      STOP:     if (slot_end) state_d = BUS_FREE;
      BUS_FREE: if (slot_end) state_d = (addr_q[0] && !phase2_q) ? START : IDLE;
    endcase
  end

  // Datapath and line-drive logic.
  always_comb begin
    cnt_d      = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    qtr_d      = tick ? qtr_q + 2'd1 : qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    phase2_d   = phase2_q;
    addr_d     = addr_q;
    sub_d      = sub_q;
    wdat_d     = wdat_q;
    rx_d       = rx_q;
    data_rd_d  = data_rd_q;
    ack_err_d  = ack_err_q;
    busy_d     = busy_q;
    scl_low_d  = 1'b0;
    sda_low_d  = 1'b0;
    sda_sync_d = {sda_sync_q[0], sda};

    unique case (state_q)
      IDLE: begin
        qtr_d = 2'd0;
        if (req.ena) begin
          addr_d    = req.addr;
          sub_d     = req.sub_addr;
          wdat_d    = req.data_wr;
          ack_err_d = 1'b0;
          phase2_d  = 1'b0;
          byte_d    = 2'd0;
          bit_d     = 3'd7;
          busy_d    = 1'b1;
        end
      end
      START: begin
        sda_low_d = (qtr_q >= 2'd2);
        scl_low_d = (qtr_q == 2'd3);
      end
      TX_BYTE: begin
        scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_low_d = !tx_bit;
        if (slot_end) bit_d = bit_q - 3'd1;
      end
      RX_ACK: begin
        scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        if (tick && qtr_q == 2'd2 && sda_in) ack_err_d = 1'b1;
        if (slot_end) byte_d = byte_q + 2'd1;
      end
      RX_BYTE: begin
        scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        if (tick && qtr_q == 2'd2) rx_d = {rx_q[6:0], sda_in};
        if (slot_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) data_rd_d = rx_q;
        end
      end
      TX_NACK: begin
        scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      STOP: begin
        scl_low_d = (qtr_q == 2'd0);
        sda_low_d = (qtr_q < 2'd2);
      end
      BUS_FREE: begin
        if (slot_end) begin
          if (addr_q[0] && !phase2_q) begin
            phase2_d = 1'b1;
            byte_d   = 2'd0;
          end else begin
            busy_d = 1'b0;
          end
        end
      end
    endcase
  end

  assign scl         = scl_low_q ? 1'b0 : 1'bz;
  assign sda         = sda_low_q ? 1'b0 : 1'bz;
  assign req.data_rd = data_rd_q;
  assign req.busy    = busy_q;
  assign req.ack_err = ack_err_q;
endmodule
